// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM states, latched mode bits and the
// toggle-counter sizing.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        DONE
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int TOGGLE_CNT_WIDTH   = $clog2(2 * DEFAULT_DATA_WIDTH + 1);

    // Counter width able to hold 0..2*data_width SCLK toggles.
    function automatic int toggle_cnt_width(input int data_width);
        return $clog2(2 * data_width + 1);
    endfunction

endpackage

// File: rtl/spi_clock_div.sv
// Half-period tick generator: latches the divider at load time and emits a
// one-cycle tick every divider+1 enabled clocks.
module spi_clock_div #(
    parameter int DIVIDER_WIDTH = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_load,
    input  logic                     i_enable,
    input  logic [DIVIDER_WIDTH-1:0] i_divider,
    output logic                     o_tick
);

    logic [DIVIDER_WIDTH-1:0] divider_reg;
    logic [DIVIDER_WIDTH-1:0] count_reg;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            divider_reg <= '0;
            count_reg   <= '0;
        end else if (i_load) begin
            divider_reg <= i_divider;
            count_reg   <= '0;
        end else if (i_enable) begin
            if (count_reg == divider_reg) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign o_tick = i_enable && (count_reg == divider_reg);

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised full-duplex SPI master with all CPOL/CPHA modes, selectable
// bit order and one-hot active-low chip selects.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DIVIDER_WIDTH = 8,
    parameter int NUM_CS        = 4,
    parameter int CS_SEL_WIDTH  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_start,
    input  logic [CS_SEL_WIDTH-1:0]  i_cs_select,
    input  logic                     i_cpol,
    input  logic                     i_cpha,
    input  logic                     i_lsb_first,
    input  logic [DIVIDER_WIDTH-1:0] i_divider,
    input  logic [DATA_WIDTH-1:0]    i_data_in,
    output logic [DATA_WIDTH-1:0]    o_data_out,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [NUM_CS-1:0]        o_spi_cs_n,
    output logic                     o_spi_clock,
    output logic                     o_spi_mosi,
    input  logic                     i_spi_miso
);

    localparam int TW = toggle_cnt_width(DATA_WIDTH);
    localparam logic [TW-1:0] LAST_TOGGLE = TW'(2 * DATA_WIDTH);
    localparam logic [TW-1:0] FIRST_TOGGLE = TW'(1);

    spi_state_t              state_reg;
    spi_mode_t               mode_reg;
    logic [DATA_WIDTH-1:0]   tx_reg;
    logic [DATA_WIDTH-1:0]   rx_reg;
    logic [DATA_WIDTH-1:0]   data_out_reg;
    logic [TW-1:0]           toggle_cnt_reg;
    logic                    sclk_reg;
    logic                    mosi_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [NUM_CS-1:0]       cs_n_reg;

    logic                    tick;
    logic                    div_enable;
    logic                    start_accept;
    logic [NUM_CS-1:0]       cs_n_sel;
    logic [TW-1:0]           toggle_num;
    logic                    do_toggle;
    logic                    is_leading;
    logic                    do_sample;
    logic                    do_shift;
    logic [DATA_WIDTH-1:0]   tx_shifted;
    logic [DATA_WIDTH-1:0]   rx_shifted;

    assign start_accept = (state_reg == IDLE) && i_start;
    assign div_enable   = (state_reg == LEAD) || (state_reg == XFER) || (state_reg == TRAIL);

    spi_clock_div #(
        .DIVIDER_WIDTH(DIVIDER_WIDTH)
    ) u_clock_div (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (start_accept),
        .i_enable  (div_enable),
        .i_divider (i_divider),
        .o_tick    (tick)
    );

    // An out-of-range select matches no line, so every CS stays high.
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
        assign cs_n_sel[gi] = (int'(i_cs_select) != gi);
    end

    // The tick that ends LEAD makes toggle 1; XFER's final tick makes none.
    always_comb begin
        toggle_num = toggle_cnt_reg + 1'b1;
        do_toggle  = tick && ((state_reg == LEAD) ||
                              ((state_reg == XFER) && (toggle_cnt_reg != LAST_TOGGLE)));
        is_leading = toggle_num[0];
        do_sample  = do_toggle && (is_leading ^ mode_reg.cpha);
        do_shift   = do_toggle && (mode_reg.cpha ? (is_leading && (toggle_num != FIRST_TOGGLE))
                                                 : (!is_leading && (toggle_num != LAST_TOGGLE)));
    end

    assign tx_shifted = mode_reg.lsb_first ? {1'b0, tx_reg[DATA_WIDTH-1:1]}
                                           : {tx_reg[DATA_WIDTH-2:0], 1'b0};
    assign rx_shifted = mode_reg.lsb_first ? {i_spi_miso, rx_reg[DATA_WIDTH-1:1]}
                                           : {rx_reg[DATA_WIDTH-2:0], i_spi_miso};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg      <= IDLE;
            mode_reg       <= '0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            data_out_reg   <= '0;
            toggle_cnt_reg <= '0;
            sclk_reg       <= 1'b0;
            mosi_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cs_n_reg       <= '1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sclk_reg <= i_cpol;
                    if (i_start) begin
                        mode_reg.cpol      <= i_cpol;
                        mode_reg.cpha      <= i_cpha;
                        mode_reg.lsb_first <= i_lsb_first;
                        tx_reg             <= i_data_in;
                        rx_reg             <= '0;
                        mosi_reg           <= i_lsb_first ? i_data_in[0] : i_data_in[DATA_WIDTH-1];
                        toggle_cnt_reg     <= '0;
                        cs_n_reg           <= cs_n_sel;
                        busy_reg           <= 1'b1;
                        state_reg          <= LEAD;
                    end
                end
                LEAD, XFER: begin
                    if (do_toggle) begin
                        sclk_reg       <= ~sclk_reg;
                        toggle_cnt_reg <= toggle_num;
                    end
                    if (do_sample) begin
                        rx_reg <= rx_shifted;
                    end
                    if (do_shift) begin
                        tx_reg   <= tx_shifted;
                        mosi_reg <= mode_reg.lsb_first ? tx_shifted[0] : tx_shifted[DATA_WIDTH-1];
                    end
                    if (tick) begin
                        if ((state_reg == XFER) && (toggle_cnt_reg == LAST_TOGGLE)) begin
                            sclk_reg  <= mode_reg.cpol;
                            state_reg <= TRAIL;
                        end else begin
                            state_reg <= XFER;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        data_out_reg <= rx_reg;
                        cs_n_reg     <= '1;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_data_out  = data_out_reg;
    assign o_busy      = busy_reg;
    assign o_done      = done_reg;
    assign o_spi_cs_n  = cs_n_reg;
    assign o_spi_clock = sclk_reg;
    assign o_spi_mosi  = mosi_reg;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a protocol-level SPI slave model observes SCLK
// edges, exchanges a word with the master and reports what it saw.
module tb_spi_master_multi;

    localparam int DW   = 8;
    localparam int DIVW = 8;
    localparam int NCS  = 4;
    localparam int CSW  = 3;

    logic            i_clock = 1'b0;
    logic            i_reset_n = 1'b1;
    logic            i_start = 1'b0;
    logic [CSW-1:0]  i_cs_select = '0;
    logic            i_cpol = 1'b0;
    logic            i_cpha = 1'b0;
    logic            i_lsb_first = 1'b0;
    logic [DIVW-1:0] i_divider = '0;
    logic [DW-1:0]   i_data_in = '0;
    logic [DW-1:0]   o_data_out;
    logic            o_busy;
    logic            o_done;
    logic [NCS-1:0]  o_spi_cs_n;
    logic            o_spi_clock;
    logic            o_spi_mosi;
    logic            i_spi_miso;

    logic            loopback = 1'b0;
    logic            slave_miso = 1'b0;

    assign i_spi_miso = loopback ? o_spi_mosi : slave_miso;

    always #5 i_clock = ~i_clock;

    spi_master_multi #(
        .DATA_WIDTH   (DW),
        .DIVIDER_WIDTH(DIVW),
        .NUM_CS       (NCS),
        .CS_SEL_WIDTH (CSW)
    ) dut (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_start     (i_start),
        .i_cs_select (i_cs_select),
        .i_cpol      (i_cpol),
        .i_cpha      (i_cpha),
        .i_lsb_first (i_lsb_first),
        .i_divider   (i_divider),
        .i_data_in   (i_data_in),
        .o_data_out  (o_data_out),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_spi_cs_n  (o_spi_cs_n),
        .o_spi_clock (o_spi_clock),
        .o_spi_mosi  (o_spi_mosi),
        .i_spi_miso  (i_spi_miso)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the most recent transfer
    int             obs_busy;
    int             obs_done;
    int             obs_done_cycle;
    int             obs_toggles;
    int             obs_first_toggle;
    int             exp_busy;
    logic           cs_err;
    logic [DW-1:0]  slave_rx;
    logic [DW-1:0]  mosi_seq;
    logic           idle_sclk;
    logic           sclk_after;
    logic [DW-1:0]  data_out_after;
    logic [DW-1:0]  data_out_mid;
    logic [NCS-1:0] cs_mid;

    task automatic do_xfer(input logic [DW-1:0] data, input logic cpol, input logic cpha,
                           input logic lsb, input logic [DIVW-1:0] div, input logic [CSW-1:0] cs,
                           input logic [DW-1:0] sword, input logic glitch);
        int             h;
        int             tx_idx;
        int             rx_idx;
        logic           prev_sclk;
        logic           leading;
        logic [NCS-1:0] one;
        logic [NCS-1:0] exp_cs;
        @(negedge i_clock);
        i_cpol      = cpol;
        i_cpha      = cpha;
        i_lsb_first = lsb;
        i_divider   = div;
        i_cs_select = cs;
        i_data_in   = data;
        @(negedge i_clock);
        idle_sclk = o_spi_clock;
        i_start   = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;

        h        = int'(div) + 1;
        exp_busy = h * (2 * DW + 2);
        one      = 1;
        exp_cs   = (int'(cs) < NCS) ? ~(one << cs) : '1;
        prev_sclk = cpol;
        tx_idx = 0;
        rx_idx = 0;
        slave_rx = '0;
        mosi_seq = '0;
        slave_miso = 1'b0;
        obs_busy = 0;
        obs_done = 0;
        obs_done_cycle = -1;
        obs_toggles = 0;
        obs_first_toggle = -1;
        cs_err = 1'b0;

        for (int c = 1; c <= exp_busy + 40; c++) begin
            if (c > 1) @(negedge i_clock);
            if (glitch && c == 3) begin
                i_start = 1'b1;
                i_data_in = ~data;
                i_divider = div + 8'd3;
                i_cs_select = cs + 3'd1;
                i_lsb_first = ~lsb;
            end
            if (glitch && c == 6) begin
                i_start = 1'b0;
                i_data_in = data;
                i_divider = div;
                i_cs_select = cs;
                i_lsb_first = lsb;
            end
            if (c == 2) begin
                data_out_mid = o_data_out;
                cs_mid = o_spi_cs_n;
            end
            if (c == 1 && !cpha) begin
                slave_miso = sword[lsb ? 0 : DW - 1];
                tx_idx = 1;
            end
            if (o_busy) obs_busy++;
            if (c <= exp_busy && o_spi_cs_n !== exp_cs) cs_err = 1'b1;
            if (o_done) begin
                obs_done++;
                if (obs_done_cycle < 0) obs_done_cycle = c;
                if (o_spi_cs_n !== '1) cs_err = 1'b1;
            end
            if (o_spi_clock !== prev_sclk) begin
                obs_toggles++;
                if (obs_first_toggle < 0) obs_first_toggle = c;
                leading = (prev_sclk == cpol);
                prev_sclk = o_spi_clock;
                if (leading ^ cpha) begin
                    if (rx_idx < DW) begin
                        slave_rx[lsb ? rx_idx : DW - 1 - rx_idx] = o_spi_mosi;
                        mosi_seq[DW - 1 - rx_idx] = o_spi_mosi;
                        rx_idx++;
                    end
                end else if (tx_idx < DW) begin
                    slave_miso = sword[lsb ? tx_idx : DW - 1 - tx_idx];
                    tx_idx++;
                end
            end
            if (obs_done_cycle > 0 && c >= obs_done_cycle + 4) break;
        end
        sclk_after = o_spi_clock;
        data_out_after = o_data_out;
        $display("xfer data=%h cpol=%0d cpha=%0d lsb=%0d div=%0d cs=%0d slave=%h -> out=%h slave_rx=%h busy=%0d done=%0d",
                 data, cpol, cpha, lsb, div, cs, sword, data_out_after, slave_rx, obs_busy, obs_done);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clock);
        n_checks++; if (o_spi_cs_n !== 4'hF) begin n_fail++; $display("FAIL reset_cs: got %b expected 1111", o_spi_cs_n); end
        n_checks++; if (o_spi_clock !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", o_spi_clock); end
        n_checks++; if (o_spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", o_spi_mosi); end
        n_checks++; if (o_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_data_out); end
        n_checks++; if ({o_busy, o_done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {o_busy, o_done}); end
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clock);
    endtask

    task automatic test_mode0_loopback();
        loopback = 1'b1;
        do_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 3'd0, 8'h00, 1'b0);
        loopback = 1'b0;
        n_checks++; if (idle_sclk !== 1'b0) begin n_fail++; $display("FAIL m0_idle_sclk: got %b expected 0", idle_sclk); end
        n_checks++; if (obs_busy !== 36) begin n_fail++; $display("FAIL m0_busy: got %0d expected 36", obs_busy); end
        n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL m0_done_count: got %0d expected 1", obs_done); end
        n_checks++; if (obs_done_cycle !== 37) begin n_fail++; $display("FAIL m0_done_cycle: got %0d expected 37", obs_done_cycle); end
        n_checks++; if (obs_first_toggle !== 3) begin n_fail++; $display("FAIL m0_first_toggle: got %0d expected 3", obs_first_toggle); end
        n_checks++; if (obs_toggles !== 16) begin n_fail++; $display("FAIL m0_toggles: got %0d expected 16", obs_toggles); end
        n_checks++; if (data_out_mid !== 8'h00) begin n_fail++; $display("FAIL m0_data_hold: got %h expected 00", data_out_mid); end
        n_checks++; if (data_out_after !== 8'hA5) begin n_fail++; $display("FAIL m0_data_out: got %h expected a5", data_out_after); end
        n_checks++; if (sclk_after !== 1'b0) begin n_fail++; $display("FAIL m0_sclk_after: got %b expected 0", sclk_after); end
        n_checks++; if (cs_err !== 1'b0) begin n_fail++; $display("FAIL m0_cs: got err=%b expected 0", cs_err); end
    endtask

    task automatic test_mode3_lsb();
        do_xfer(8'h3C, 1'b1, 1'b1, 1'b1, 8'd1, 3'd1, 8'h96, 1'b0);
        n_checks++; if (mosi_seq !== 8'b00111100) begin n_fail++; $display("FAIL m3_mosi_seq: got %b expected 00111100", mosi_seq); end
        n_checks++; if (data_out_after !== 8'h96) begin n_fail++; $display("FAIL m3_data_out: got %h expected 96", data_out_after); end
        n_checks++; if (data_out_mid !== 8'hA5) begin n_fail++; $display("FAIL m3_data_hold: got %h expected a5", data_out_mid); end
        n_checks++; if (idle_sclk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sclk: got %b expected 1", idle_sclk); end
        n_checks++; if (sclk_after !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_after: got %b expected 1", sclk_after); end
        n_checks++; if (obs_busy !== 36) begin n_fail++; $display("FAIL m3_busy: got %0d expected 36", obs_busy); end
    endtask

    task automatic test_modes_1_2();
        logic [DW-1:0] sw;
        for (int m = 1; m <= 2; m++) begin
            sw = DW'($urandom);
            do_xfer(8'h81, (m == 2), (m == 1), 1'b0, 8'd0, 3'd3, sw, 1'b0);
            n_checks++; if (obs_busy !== 18) begin n_fail++; $display("FAIL mode%0d_busy: got %0d expected 18", m, obs_busy); end
            n_checks++; if (data_out_after !== sw) begin n_fail++; $display("FAIL mode%0d_data_out: got %h expected %h", m, data_out_after, sw); end
            n_checks++; if (slave_rx !== 8'h81) begin n_fail++; $display("FAIL mode%0d_slave_rx: got %h expected 81", m, slave_rx); end
            n_checks++; if (obs_done_cycle !== 19) begin n_fail++; $display("FAIL mode%0d_done_cycle: got %0d expected 19", m, obs_done_cycle); end
        end
    endtask

    task automatic test_cs_select();
        logic [DW-1:0] sw;
        sw = DW'($urandom);
        do_xfer(DW'($urandom), 1'b0, 1'b0, 1'b0, 8'd1, 3'd2, sw, 1'b0);
        n_checks++; if (cs_mid !== 4'b1011) begin n_fail++; $display("FAIL cs2_mid: got %b expected 1011", cs_mid); end
        n_checks++; if (cs_err !== 1'b0) begin n_fail++; $display("FAIL cs2_window: got err=%b expected 0", cs_err); end
        sw = DW'($urandom);
        do_xfer(DW'($urandom), 1'b0, 1'b1, 1'b1, 8'd2, 3'd5, sw, 1'b0);
        n_checks++; if (cs_mid !== 4'b1111) begin n_fail++; $display("FAIL cs5_mid: got %b expected 1111", cs_mid); end
        n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL cs5_done: got %0d expected 1", obs_done); end
        n_checks++; if (data_out_after !== sw) begin n_fail++; $display("FAIL cs5_data_out: got %h expected %h", data_out_after, sw); end
        n_checks++; if (obs_busy !== 54) begin n_fail++; $display("FAIL cs5_busy: got %0d expected 54", obs_busy); end
    endtask

    task automatic test_ignore_start();
        logic [DW-1:0] d;
        logic [DW-1:0] sw;
        d  = DW'($urandom);
        sw = DW'($urandom);
        do_xfer(d, 1'b0, 1'b1, 1'b0, 8'd1, 3'd0, sw, 1'b1);
        n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", obs_done); end
        n_checks++; if (obs_busy !== 36) begin n_fail++; $display("FAIL ignore_busy: got %0d expected 36", obs_busy); end
        n_checks++; if (slave_rx !== d) begin n_fail++; $display("FAIL ignore_slave_rx: got %h expected %h", slave_rx, d); end
        n_checks++; if (data_out_after !== sw) begin n_fail++; $display("FAIL ignore_data_out: got %h expected %h", data_out_after, sw); end
        n_checks++; if (cs_err !== 1'b0) begin n_fail++; $display("FAIL ignore_cs: got err=%b expected 0", cs_err); end
    endtask

    task automatic test_reset_mid();
        int dones;
        logic [DW-1:0] sw;
        @(negedge i_clock);
        i_cpol = 1'b1;
        i_cpha = 1'b0;
        i_lsb_first = 1'b0;
        i_divider = 8'd1;
        i_cs_select = 3'd1;
        i_data_in = 8'h5A;
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        repeat (9) @(negedge i_clock);
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", o_busy); end
        i_reset_n = 1'b0;
        #1;
        n_checks++; if (o_spi_cs_n !== 4'hF) begin n_fail++; $display("FAIL rstmid_cs: got %b expected 1111", o_spi_cs_n); end
        n_checks++; if ({o_busy, o_done, o_spi_clock, o_spi_mosi} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ctrl: got %b expected 0000", {o_busy, o_done, o_spi_clock, o_spi_mosi}); end
        n_checks++; if (o_data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", o_data_out); end
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clock);
            if (c == 3) i_reset_n = 1'b1;
            if (o_done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
        sw = DW'($urandom);
        do_xfer(8'hC3, 1'b0, 1'b0, 1'b1, 8'd0, 3'd1, sw, 1'b0);
        n_checks++; if (data_out_after !== sw) begin n_fail++; $display("FAIL rstmid_recover_data: got %h expected %h", data_out_after, sw); end
        n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL rstmid_recover_done: got %0d expected 1", obs_done); end
    endtask

    task automatic test_random();
        logic [DW-1:0]   d;
        logic [DW-1:0]   sw;
        logic [DIVW-1:0] dv;
        logic [CSW-1:0]  cs;
        logic [2:0]      md;
        int              eb;
        for (int t = 0; t < 6; t++) begin
            d  = DW'($urandom);
            sw = DW'($urandom);
            dv = DIVW'($urandom_range(0, 3));
            cs = CSW'($urandom_range(0, 3));
            md = 3'($urandom);
            eb = (int'(dv) + 1) * (2 * DW + 2);
            do_xfer(d, md[0], md[1], md[2], dv, cs, sw, 1'b0);
            n_checks++; if (data_out_after !== sw) begin n_fail++; $display("FAIL rand%0d_data_out: got %h expected %h", t, data_out_after, sw); end
            n_checks++; if (slave_rx !== d) begin n_fail++; $display("FAIL rand%0d_slave_rx: got %h expected %h", t, slave_rx, d); end
            n_checks++; if (obs_busy !== eb) begin n_fail++; $display("FAIL rand%0d_busy: got %0d expected %0d", t, obs_busy, eb); end
            n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d expected 1", t, obs_done); end
            n_checks++; if (cs_err !== 1'b0) begin n_fail++; $display("FAIL rand%0d_cs: got err=%b expected 0", t, cs_err); end
            n_checks++; if (sclk_after !== md[0]) begin n_fail++; $display("FAIL rand%0d_sclk_idle: got %b expected %b", t, sclk_after, md[0]); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_mode0_loopback();
        test_mode3_lsb();
        test_modes_1_2();
        test_cs_select();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master, successor to the fixed 8-bit single-slave master. It supports configurable data width, all four CPOL/CPHA modes, MSB- or LSB-first order and multiple one-hot chip selects. It performs full-duplex shifts with MISO capture and uses a start/busy/done handshake. It sits between a register/control block and the external SPI pins.

## Interface
- DATA_WIDTH, 8: bits per transfer, ≥2
- DIVIDER_WIDTH, 8: width of i_divider
- NUM_CS, 4: number of chip-select lines, ≥1
- CS_SEL_WIDTH, $clog2(NUM_CS) (min 1): width of i_cs_select
- i_clock  in  1  system clock; all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  start request; sampled only when idle
- i_cs_select  in  CS_SEL_WIDTH  target slave index
- i_cpol  in  1  SCLK idle level
- i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- i_lsb_first  in  1  bit order
- i_divider  in  DIVIDER_WIDTH  half-period = i_divider+1 system clocks (H)
- i_data_in  in  DATA_WIDTH  word to transmit
- o_data_out  out  DATA_WIDTH  last received word
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse
- o_spi_cs_n  out  NUM_CS  active-low chip selects
- o_spi_clock  out  1  SCLK
- o_spi_mosi  out  1  MOSI
- i_spi_miso  in  1  MISO

## Operation
- FSM: IDLE → LEAD → XFER → TRAIL → DONE → IDLE.
- IDLE: o_spi_clock tracks i_cpol every cycle. i_start=1 latches all config inputs and i_data_in into the shift register, then enters LEAD.
- LEAD: one half-period H. The selected CS bit is low. MOSI drives the first bit (MSB, or LSB if i_lsb_first).
- XFER: 2·DATA_WIDTH SCLK toggles, each H cycles apart.
  - CPHA=0: sample MISO on odd toggles (leading edges); shift out the next bit on even toggles (trailing edges), except after the last bit.
  - CPHA=1: shift out on leading edges; the first leading edge drives bit 0 of the order. Sample on trailing edges.
- TRAIL: one half-period H. SCLK is at CPOL and CS is still asserted.
- DONE: one cycle. All CS deasserted, o_done=1, o_busy=0. o_data_out is updated here and holds until the next DONE.
- MISO is sampled directly on the system-clock edge that toggles SCLK and is shifted into the receive register in the same bit order.
- i_start while busy is ignored. Input changes after start are ignored until the next start.
- If i_cs_select ≥ NUM_CS, the transfer runs normally with no CS asserted.
- Divider counter counts 0..H-1 and wraps. i_divider=0 gives H=1, so SCLK = i_clock/2.

## Timing
- Reset values: o_spi_cs_n all 1; o_spi_clock 0; o_spi_mosi 0; o_data_out 0; o_busy 0; o_done 0; FSM IDLE.
- Reset asserted mid-transfer returns everything to reset values immediately. There is no o_done pulse.
- i_start in cycle 0 gives: o_busy=1 and CS low from cycle 1, for exactly H·(2·DATA_WIDTH+2) cycles.
- o_done pulses in cycle 1+H·(2·DATA_WIDTH+2). CS deasserts in the same cycle.
- i_start is accepted in the DONE cycle's following cycle (IDLE). Back-to-back transfers therefore have CS high for ≥2 cycles.
- The first SCLK toggle occurs H cycles after CS assertion.
- All outputs are registered.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE, LEAD, XFER, TRAIL, DONE)
  - a spi_mode_t struct {cpol, cpha, lsb_first}
  - the localparam for the toggle-counter width, $clog2(2·DATA_WIDTH+1)
- Sub-module spi_clock_div: half-period tick generator with enable, wrap-around counter and an i_divider latch. It emits a single-cycle tick every H cycles.

## Test plan
- Mode 0, MSB-first, DATA_WIDTH=8, i_divider=1, i_data_in=0xA5, MISO looped to MOSI → o_data_out=0xA5; o_busy high 36 cycles; o_done one cycle; SCLK idles low.
- Mode 3, LSB-first, i_data_in=0x3C, MISO driven by slave model returning 0x96 → MOSI bit sequence 0,0,1,1,1,1,0,0; o_data_out=0x96; SCLK idles high.
- Modes 1 and 2, i_divider=0, i_data_in=0x81 → busy 18 cycles; sampling on trailing edge for mode 1 and leading edge for mode 2, checked by slave model; o_data_out matches model.
- i_cs_select=2, NUM_CS=4 → only o_spi_cs_n[2] low during transfer. Second transfer with i_cs_select=5 (NUM_CS=4, width 3) → all CS stay high; o_done still pulses.
- i_start reasserted and i_data_in changed mid-transfer → ignored; the original word completes; exactly one o_done.
- i_reset_n low at cycle 10 of transfer → all outputs return to reset values the same cycle; no o_done. A new start after release completes normally.
